dmem_access_ctrl: RTL and testbench

- Initiator-side controller that drives the level-sensitive DataMemory port (inData, addr, write, read, outData) from the CPU load/store stage.
- Accepts one load/store request per valid/ready handshake and sequences addr/data setup, a single-cycle read/write strobe and release.
- Captures and extends load data, then returns a response under valid/ready.
- Guarantees the memory never sees a strobe while addr or inData is changing.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/load_extend.sv | 16 +
 rtl/dmem_access_ctrl.sv | 113 +++++++++++
 tb/tb_dmem_access_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the DataMemory initiator: access codes, FSM states and latched request.
package dmem_pkg;

  localparam logic [3:0] DM_CODE_NONE = 4'd0;
  localparam logic [3:0] DM_CODE_BYTE = 4'd1;
  localparam logic [3:0] DM_CODE_WORD = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_DONE   = 2'd3
  } dm_state_t;

  typedef struct packed {
    logic we;
    logic is_byte;
    logic sign_ext;
  } dm_req_t;

  // Memory code for one access; byte accesses always use the low-lane code.
  function automatic logic [3:0] access_code(input logic is_byte, input logic [3:0] word_code);
    return is_byte ? DM_CODE_BYTE : word_code;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Byte/word select with sign or zero extension of raw memory read data.
module load_extend (
  input  logic [31:0] raw,
  input  logic        is_byte,
  input  logic        sign_ext,
  output logic [31:0] data
);

  always_comb begin
    data = raw;
    if (is_byte) begin
      data = {{24{raw[7] & sign_ext}}, raw[7:0]};
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequences one load/store per handshake onto the level-sensitive DataMemory port:
// address/data setup, single-cycle strobe, release, then a held response.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int         ADDR_BITS = 5,
  parameter logic [3:0] WORD_CODE = DM_CODE_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_inData,
  output logic [3:0]  dm_write,
  output logic [3:0]  dm_read,
  input  logic [31:0] dm_outData
);

  dm_state_t   state;
  dm_req_t     lat;
  logic [31:0] addr_hi;
  logic        addr_oor;
  logic [31:0] ext_data;

  // Any set bit above the implemented range rejects the access.
  assign addr_hi  = req_addr >> ADDR_BITS;
  assign addr_oor = |addr_hi;

  load_extend u_load_extend (
    .raw      (dm_outData),
    .is_byte  (lat.is_byte),
    .sign_ext (lat.sign_ext),
    .data     (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      lat       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      dm_addr   <= 32'd0;
      dm_inData <= 32'd0;
      dm_write  <= DM_CODE_NONE;
      dm_read   <= DM_CODE_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            lat       <= '{we: req_we, is_byte: req_byte, sign_ext: req_signed};
            req_ready <= 1'b0;
            if (addr_oor) begin
              state     <= ST_DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'd0;
            end else begin
              // Address and data settle a full cycle before any strobe.
              state     <= ST_SETUP;
              dm_addr   <= req_addr;
              dm_inData <= req_we ? req_wdata : 32'd0;
              dm_write  <= DM_CODE_NONE;
              dm_read   <= DM_CODE_NONE;
            end
          end
        end

        ST_SETUP: begin
          state <= ST_STROBE;
          if (lat.we) begin
            dm_write <= access_code(lat.is_byte, WORD_CODE);
          end else begin
            dm_read  <= access_code(lat.is_byte, WORD_CODE);
          end
        end

        ST_STROBE: begin
          state     <= ST_DONE;
          dm_write  <= DM_CODE_NONE;
          dm_read   <= DM_CODE_NONE;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= lat.we ? 32'd0 : ext_data;
        end

        ST_DONE: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench: a memory model behind the DataMemory port, a reference array for expected data,
// and independent monitors for strobes and responses.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_byte, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] dm_addr, dm_inData, dm_outData;
  logic [3:0]  dm_write, dm_read;

  always #5 clk = ~clk;

  dmem_access_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_byte   (req_byte),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .dm_addr    (dm_addr),
    .dm_inData  (dm_inData),
    .dm_write   (dm_write),
    .dm_read    (dm_read),
    .dm_outData (dm_outData)
  );

  // DataMemory stand-in: 32 words, writes commit at the clock edge while a write code is held.
  logic [31:0] mem [32];
  logic        clear_mem;
  always @(posedge clk) begin
    if (clear_mem) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
    end else if (dm_write == 4'hF) begin
      mem[dm_addr[4:0]] <= dm_inData;
    end else if (dm_write == 4'd1) begin
      mem[dm_addr[4:0]][7:0] <= dm_inData[7:0];
    end
  end
  assign dm_outData = (dm_read != 4'd0) ? mem[dm_addr[4:0]] : 32'd0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } rsp_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wcode;
    logic [3:0]  rcode;
  } stb_exp_t;

  rsp_exp_t    rq[$];
  stb_exp_t    sq[$];
  logic [31:0] ref_mem [32];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          hold = 0;
  bit          bp_rand = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Strobe monitor: one-cycle, exclusive, preceded by a quiet cycle with the same addr/data.
  logic [31:0] prev_addr = 32'd0, prev_data = 32'd0;
  logic [3:0]  prev_w = 4'd0, prev_r = 4'd0;
  always @(negedge clk) begin
    stb_exp_t e;
    if (rst_n && (dm_write != 4'd0 || dm_read != 4'd0)) begin
      chk("strobe_exclusive", 32'(dm_write != 4'd0 && dm_read != 4'd0), 32'd0);
      chk("strobe_after_quiet", {24'd0, prev_w, prev_r}, 32'd0);
      chk("strobe_addr_stable", dm_addr, prev_addr);
      chk("strobe_data_stable", dm_inData, prev_data);
      chk("strobe_expected", 32'(sq.size() > 0), 32'd1);
      if (sq.size() > 0) begin
        e = sq.pop_front();
        chk("strobe_addr", dm_addr, e.addr);
        chk("strobe_data", dm_inData, e.data);
        chk("strobe_write_code", {28'd0, dm_write}, {28'd0, e.wcode});
        chk("strobe_read_code", {28'd0, dm_read}, {28'd0, e.rcode});
      end
    end
    prev_addr = dm_addr;
    prev_data = dm_inData;
    prev_w    = dm_write;
    prev_r    = dm_read;
  end

  // Response monitor: owns rsp_ready; checks latency, stability under backpressure and payload.
  logic        prev_rv = 1'b0, prev_rr = 1'b0, prev_err = 1'b0, after_hs = 1'b0;
  logic [31:0] prev_rd = 32'd0;
  always @(negedge clk) begin
    rsp_exp_t e;
    if (!rst_n) begin
      rsp_ready = 1'b1;
      prev_rv   = 1'b0;
      after_hs  = 1'b0;
    end else begin
      if (after_hs) begin
        chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
        after_hs = 1'b0;
      end
      if (rsp_valid && !prev_rv) begin
        chk("rsp_expected", 32'(rq.size() > 0), 32'd1);
        if (rq.size() > 0) chk("rsp_latency", 32'(cyc - rq[0].acc), 32'(rq[0].lat));
      end
      if (rsp_valid && prev_rv && !prev_rr) begin
        chk("rsp_rdata_stable", rsp_rdata, prev_rd);
        chk("rsp_err_stable", {31'd0, rsp_err}, {31'd0, prev_err});
      end
      if (rsp_valid) chk("req_ready_low_while_rsp", {31'd0, req_ready}, 32'd0);
      if (rsp_valid && hold > 0) begin
        rsp_ready = 1'b0;
        hold--;
      end else begin
        rsp_ready = bp_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      if (rsp_valid && rsp_ready && rq.size() > 0) begin
        e = rq.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        after_hs = 1'b1;
      end
      prev_rv  = rsp_valid;
      prev_rr  = rsp_ready;
      prev_rd  = rsp_rdata;
      prev_err = rsp_err;
    end
  end

  // Called at a falling edge; returns at a falling edge after the handshake.
  task automatic issue(input logic we, input logic byt, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input bit track);
    int       waited = 0;
    bit       oor;
    rsp_exp_t r;
    stb_exp_t s;
    logic [31:0] w;
    logic [7:0]  b;
    req_we = we; req_byte = byt; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("req_accept_in_time", {31'd0, req_ready}, 32'd1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    oor = (addr[31:5] != 27'd0);
    if (!oor) begin
      s.addr  = addr;
      s.data  = we ? wdata : 32'd0;
      s.wcode = we ? (byt ? 4'd1 : 4'hF) : 4'd0;
      s.rcode = we ? 4'd0 : (byt ? 4'd1 : 4'hF);
      sq.push_back(s);
    end
    if (track) begin
      r.acc   = cyc;
      r.lat   = oor ? 1 : 3;
      r.err   = oor;
      r.rdata = 32'd0;
      if (!oor && we) begin
        if (byt) ref_mem[addr[4:0]][7:0] = wdata[7:0];
        else     ref_mem[addr[4:0]]      = wdata;
      end else if (!oor) begin
        w = ref_mem[addr[4:0]];
        b = w[7:0];
        if (!byt)           r.rdata = w;
        else if (sgn && b[7]) r.rdata = {24'hFFFFFF, b};
        else                r.rdata = {24'h0, b};
      end
      rq.push_back(r);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((rq.size() != 0 || sq.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_rsp_queue", 32'(rq.size()), 32'd0);
    chk("drain_strobe_queue", 32'(sq.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int t;
    rst_n = 1'b0; clear_mem = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("reset_dm_addr", dm_addr, 32'd0);
    chk("reset_dm_inData", dm_inData, 32'd0);
    chk("reset_dm_codes", {24'd0, dm_write, dm_read}, 32'd0);
    rst_n = 1'b1; clear_mem = 1'b0;
    @(negedge clk);

    issue(1, 0, 0, 32'd3, 32'hDEADBEEF, 1);
    issue(0, 0, 0, 32'd3, 32'h0, 1);
    issue(1, 0, 0, 32'd7, 32'h000000F0, 1);
    issue(0, 1, 1, 32'd7, 32'h0, 1);
    issue(0, 1, 0, 32'd7, 32'h0, 1);
    issue(1, 0, 0, 32'd2, 32'h11223344, 1);
    issue(1, 1, 0, 32'd2, 32'hAAAAAA55, 1);
    issue(0, 0, 0, 32'd2, 32'h0, 1);
    issue(0, 0, 0, 32'h00000020, 32'h0, 1);
    drain();

    hold = 5;
    issue(0, 0, 0, 32'd3, 32'h0, 1);
    issue(1, 0, 0, 32'd5, 32'h5A5A5A5A, 1);
    drain();

    // Abort a store during its strobe cycle; memory keeps its previous word.
    issue(1, 0, 0, 32'd9, 32'hCAFEF00D, 0);
    t = 0;
    while (dm_write == 4'd0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("reset_test_saw_strobe", {28'd0, dm_write}, 32'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_dm_write", {28'd0, dm_write}, 32'd0);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_abort_dm_write", {28'd0, dm_write}, 32'd0);
    chk("post_abort_req_ready", {31'd0, req_ready}, 32'd1);
    chk("post_abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    issue(0, 0, 0, 32'd9, 32'h0, 1);
    drain();

    bp_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      a = $urandom;
      if ($urandom_range(0, 7) != 0) a = {27'd0, a[4:0]};
      else if (a[31:5] == 27'd0) a[5] = 1'b1;
      issue($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), a, $urandom, 1);
      if ($urandom_range(0, 9) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
